// File: rtl/au_issue_ctrl.sv
// au_issue_ctrl
//   Issue/sequencing stage in front of the 32-bit arithmetic unit (ADD/SUB/MULT/DIV).
//   Accepts one operation per req handshake, holds operands/opcode steady on au_*
//   for the op-specific latency, captures s/hi/lo with zero and divide-by-zero
//   flags, and presents the result on the rsp handshake until it is consumed.
// Ports
//   clk, rst_n            clock; asynchronous reset, active-high (1 = reset)
//   req_valid/req_ready   request handshake; req_ready only in IDLE
//   req_op/req_a/req_b    opcode (00 ADD, 01 SUB, 10 MULT, 11 DIV) and operands
//   au_a/au_b/au_op       latched operands/opcode driven to the AU
//   au_s/au_hi/au_lo      AU results
//   rsp_valid/rsp_ready   response handshake
//   rsp_s/rsp_hi/rsp_lo   captured results
//   rsp_zero/rsp_dbz      zero flag, divide-by-zero flag
//   busy                  operation in flight (state != IDLE)
module au_issue_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDSUB_CYC = 1,
  parameter int unsigned MULT_CYC   = 32,
  parameter int unsigned DIV_CYC    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [1:0]       au_op,
  input  logic [WIDTH-1:0] au_s,
  input  logic [WIDTH-1:0] au_hi,
  input  logic [WIDTH-1:0] au_lo,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_zero,
  output logic             rsp_dbz,
  output logic             busy
);

  localparam int unsigned MAX_AM  = (ADDSUB_CYC > MULT_CYC) ? ADDSUB_CYC : MULT_CYC;
  localparam int unsigned MAX_CYC = (MAX_AM > DIV_CYC) ? MAX_AM : DIV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;

  // S_DBZ is a single bookkeeping cycle so divide-by-zero keeps the same
  // one-cycle response latency as a single-cycle op without entering EXEC.
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DBZ, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_load;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   s_q, s_d, hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, dbz_q, dbz_d;

  always_comb begin
    case (req_op)
      OP_ADD, OP_SUB: cnt_load = CNT_W'(ADDSUB_CYC - 1);
      OP_MULT:        cnt_load = CNT_W'(MULT_CYC - 1);
      default:        cnt_load = CNT_W'(DIV_CYC - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    s_d     = s_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d  = req_a;
          b_d  = req_b;
          op_d = req_op;
          if (req_op == 2'b11 && req_b == '0) begin
            cnt_d   = '0;
            state_d = S_DBZ;
          end else begin
            cnt_d   = cnt_load;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          dbz_d = 1'b0;
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            s_d    = au_s;
            hi_d   = '0;
            lo_d   = '0;
            zero_d = (au_s == '0);
          end else begin
            s_d    = '0;
            hi_d   = au_hi;
            lo_d   = au_lo;
            zero_d = ({au_hi, au_lo} == '0);
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DBZ: begin
        s_d     = '0;
        hi_d    = '0;
        lo_d    = '0;
        zero_d  = 1'b1;
        dbz_d   = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        if (rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      s_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      s_q     <= s_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign au_a      = a_q;
  assign au_b      = b_q;
  assign au_op     = op_q;
  assign rsp_s     = s_q;
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_zero  = zero_q;
  assign rsp_dbz   = dbz_q;

endmodule

// File: tb/tb_au_issue_ctrl.sv
// tb_au_issue_ctrl
//   Directed and random operations for au_issue_ctrl. A behavioural AU drives
//   au_s/au_hi/au_lo from the DUT's au_* outputs; expected results, flags and
//   latencies come from a separate arithmetic reference computed from the request.
module tb_au_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] au_a, au_b;
  logic [1:0]  au_op;
  logic [31:0] au_s, au_hi, au_lo;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_s, rsp_hi, rsp_lo;
  logic        rsp_zero, rsp_dbz, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  au_issue_ctrl #(
    .WIDTH(32), .ADDSUB_CYC(1), .MULT_CYC(32), .DIV_CYC(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .au_a(au_a), .au_b(au_b), .au_op(au_op),
    .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_zero(rsp_zero), .rsp_dbz(rsp_dbz), .busy(busy)
  );

  // Behavioural arithmetic unit
  logic [63:0] au_prod;
  always_comb begin
    au_prod = {32'b0, au_a} * {32'b0, au_b};
    au_s    = au_op[0] ? (au_a - au_b) : (au_a + au_b);
    au_hi   = 32'hDEAD_BEEF;
    au_lo   = 32'hCAFE_F00D;
    if (au_op == 2'b10) begin
      au_hi = au_prod[63:32];
      au_lo = au_prod[31:0];
    end else if (au_op == 2'b11 && au_b != 0) begin
      au_hi = au_a % au_b;
      au_lo = au_a / au_b;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: result fields and latency derived from the op definition
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall);
    logic [31:0] e_s, e_hi, e_lo;
    logic        e_zero, e_dbz;
    logic [63:0] full;
    int          e_lat, lat, w;
    e_s = 0; e_hi = 0; e_lo = 0; e_dbz = 0;
    case (op)
      2'b00: begin e_s = a + b; e_lat = 1; end
      2'b01: begin e_s = a - b; e_lat = 1; end
      2'b10: begin full = 64'(a) * 64'(b); e_hi = full[63:32]; e_lo = full[31:0]; e_lat = 32; end
      default: begin
        if (b == 0) begin e_dbz = 1; e_lat = 1; end
        else begin e_hi = a % b; e_lo = a / b; e_lat = 32; end
      end
    endcase
    e_zero = (op < 2) ? (e_s == 0) : ({e_hi, e_lo} == 0);

    w = 0;
    while (!req_ready && w < 100) begin step(); w++; end
    chk("req_ready_before_accept", req_ready, 1);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    step();
    req_valid = 0; req_op = ~op; req_a = ~a; req_b = ~b;
    chk("busy_after_accept", busy, 1);
    chk("req_ready_after_accept", req_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      if (!e_dbz) begin
        chk("au_op_hold", au_op, op);
        chk("au_a_hold", au_a, a);
        chk("au_b_hold", au_b, b);
      end
      // a request offered while busy must be ignored
      req_valid = (lat == 2);
      step();
      req_valid = 0;
      lat++;
    end
    chk("latency", lat, e_lat);
    rsp_ready = 0;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) rsp_ready = 1;
      chk("rsp_valid", rsp_valid, 1);
      chk("req_ready_in_done", req_ready, 0);
      chk("rsp_s", rsp_s, e_s);
      chk("rsp_hi", rsp_hi, e_hi);
      chk("rsp_lo", rsp_lo, e_lo);
      chk("rsp_zero", rsp_zero, e_zero);
      chk("rsp_dbz", rsp_dbz, e_dbz);
      if (!e_dbz) chk("au_op_done_hold", au_op, op);
      step();
    end
    rsp_ready = 0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("busy_after_hs", busy, 0);
    chk("req_ready_after_hs", req_ready, 1);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; rsp_ready = 0;
    step(); step();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_s, rsp_hi}, 0);
    chk("rst_rsp_lo_flags", {rsp_lo, rsp_zero, rsp_dbz}, 0);
    chk("rst_au", {au_a, au_b}, 0);
    chk("rst_au_op", au_op, 0);
    rst_n = 0;
    step();

    do_op(2'b00, 5, 7, 0);
    do_op(2'b01, 9, 9, 0);
    do_op(2'b10, 32'h10000, 32'h10000, 0);
    do_op(2'b11, 100, 0, 0);
    do_op(2'b11, 100, 7, 10);
    do_op(2'b00, 32'hFFFF_FFFF, 1, 2);
    do_op(2'b10, 0, 32'h1234, 1);

    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 0;
        1: ra = 0;
        2: rb = ra;
        3: begin ra = $urandom_range(0, 20); rb = $urandom_range(0, 4); end
        default: ;
      endcase
      do_op(rop, ra, rb, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a MULT
    req_valid = 1; req_op = 2'b10; req_a = 3; req_b = 4;
    step();
    req_valid = 0;
    repeat (9) step();
    chk("mid_mult_busy", busy, 1);
    #2 rst_n = 1;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_au_op", au_op, 0);
    chk("mid_rst_au_a", au_a, 0);
    step();
    rst_n = 0;
    step();
    chk("post_rst_idle", req_ready, 1);
    do_op(2'b01, 3, 10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
